// File: rtl/next_pc_predictor.sv
// next_pc_predictor: fetch-stage next-PC unit built around a direct-mapped
// branch target buffer with 2-bit saturating counters. Fetch gets a
// zero-latency prediction. Execute-side resolution updates the table and
// raises a registered redirect whenever the carried prediction was wrong.
//
// Optional feature: define NPC_BYPASS_EN to forward a same-cycle table update
// into the lookup when resolve and fetch hit the same index.
module next_pc_predictor #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fetch_pc,
    output logic [WIDTH-1:0] pred_next_pc,
    output logic             pred_taken,
    input  logic             resolve_valid,
    input  logic [WIDTH-1:0] resolve_pc,
    input  logic             resolve_is_branch,
    input  logic             resolve_is_jump,
    input  logic             resolve_is_jr,
    input  logic             resolve_cond,
    input  logic [WIDTH-1:0] resolve_immed,
    input  logic [WIDTH-1:0] resolve_jr_target,
    input  logic             resolve_pred_taken,
    input  logic [WIDTH-1:0] resolve_pred_pc,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [15:0]      miss_count
);

    localparam int IDX = $clog2(DEPTH);
    localparam int TW  = WIDTH - IDX - 1;

    // Only the valid bits need a reset; the payload is qualified by them.
    logic [DEPTH-1:0] valid;
    logic [TW-1:0]    tag_mem    [DEPTH];
    logic [WIDTH-1:0] target_mem [DEPTH];
    logic [1:0]       ctr_mem    [DEPTH];

    // Resolution compares the full predicted PC, so the carried taken bit
    // is not needed here.
    logic unused_pred_taken;
    assign unused_pred_taken = resolve_pred_taken;

    logic [IDX-1:0]   r_idx;
    logic [TW-1:0]    r_tag;
    logic             is_jump;
    logic             is_branch;
    logic             is_control;
    logic             is_jr;
    logic             taken;
    logic [WIDTH-1:0] incr;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] actual;
    logic             mispredict;
    logic             r_hit;

    // Decode the resolving instruction; a jump wins over a branch, and a
    // register target only counts when it comes with a jump.
    always_comb begin
        r_idx      = resolve_pc[IDX:1];
        r_tag      = resolve_pc[WIDTH-1:IDX+1];
        is_jump    = resolve_is_jump;
        is_branch  = resolve_is_branch & ~resolve_is_jump;
        is_control = is_jump | is_branch;
        is_jr      = resolve_is_jump & resolve_is_jr;
        taken      = is_jump | (is_branch & resolve_cond);
        incr       = resolve_pc + WIDTH'(2);
        target     = is_jr ? resolve_jr_target : incr + resolve_immed;
        actual     = taken ? target : incr;
        mispredict = (resolve_pred_pc != actual);
        r_hit      = valid[r_idx] && (tag_mem[r_idx] == r_tag);
    end

    logic             new_valid;
    logic [TW-1:0]    new_tag;
    logic [WIDTH-1:0] new_target;
    logic [1:0]       new_ctr;

    // Build the post-update image of the resolve entry; no-change cases keep old contents.
    always_comb begin
        new_valid  = valid[r_idx];
        new_tag    = tag_mem[r_idx];
        new_target = target_mem[r_idx];
        new_ctr    = ctr_mem[r_idx];
        if (is_control) begin
            if (!r_hit) begin
                if (taken) begin
                    new_valid  = 1'b1;
                    new_tag    = r_tag;
                    new_target = target;
                    new_ctr    = is_jump ? 2'b11 : 2'b10;
                end
            end else if (taken) begin
                new_target = target;
                new_ctr    = (ctr_mem[r_idx] == 2'b11) ? 2'b11 : ctr_mem[r_idx] + 2'd1;
            end else begin
                new_ctr    = (ctr_mem[r_idx] == 2'b00) ? 2'b00 : ctr_mem[r_idx] - 2'd1;
            end
        end else if (r_hit) begin
            new_valid = 1'b0;
        end
    end

    // Valid bits: cleared on reset, otherwise written with the resolve entry image.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (resolve_valid) begin
            valid[r_idx] <= new_valid;
        end
    end

    // Entry payload: written on any non-reset resolve, never reset itself.
    always_ff @(posedge clk) begin
        if (rst_n && resolve_valid) begin
            tag_mem[r_idx]    <= new_tag;
            target_mem[r_idx] <= new_target;
            ctr_mem[r_idx]    <= new_ctr;
        end
    end

    logic [IDX-1:0]   f_idx;
    logic [TW-1:0]    f_tag;
    logic             l_valid;
    logic [TW-1:0]    l_tag;
    logic [WIDTH-1:0] l_target;
    logic [1:0]       l_ctr;

    // Fetch lookup, optionally forwarding a same-index update from this cycle.
    always_comb begin
        f_idx    = fetch_pc[IDX:1];
        f_tag    = fetch_pc[WIDTH-1:IDX+1];
        l_valid  = valid[f_idx];
        l_tag    = tag_mem[f_idx];
        l_target = target_mem[f_idx];
        l_ctr    = ctr_mem[f_idx];
`ifdef NPC_BYPASS_EN
        if (resolve_valid && (r_idx == f_idx)) begin
            l_valid  = new_valid;
            l_tag    = new_tag;
            l_target = new_target;
            l_ctr    = new_ctr;
        end
`else
`endif
        pred_taken   = l_valid && (l_tag == f_tag) && l_ctr[1];
        pred_next_pc = pred_taken ? l_target : fetch_pc + WIDTH'(2);
    end

    // Registered redirect pulse with held target and saturating miss counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
            miss_count  <= '0;
        end else begin
            redirect <= resolve_valid && mispredict;
            if (resolve_valid && mispredict) begin
                redirect_pc <= actual;
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_next_pc_predictor.sv
// tb_next_pc_predictor: directed vectors with hand-computed expectations for
// the BTB-based next-PC predictor (WIDTH=16, DEPTH=8).
module tb_next_pc_predictor;

    logic        clk;
    logic        rst_n;
    logic [15:0] fetch_pc;
    logic [15:0] pred_next_pc;
    logic        pred_taken;
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic        resolve_is_branch;
    logic        resolve_is_jump;
    logic        resolve_is_jr;
    logic        resolve_cond;
    logic [15:0] resolve_immed;
    logic [15:0] resolve_jr_target;
    logic        resolve_pred_taken;
    logic [15:0] resolve_pred_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] miss_count;

    int compareCount = 0;
    int mismatchCount = 0;

    next_pc_predictor #(.WIDTH(16), .DEPTH(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_pc           (fetch_pc),
        .pred_next_pc       (pred_next_pc),
        .pred_taken         (pred_taken),
        .resolve_valid      (resolve_valid),
        .resolve_pc         (resolve_pc),
        .resolve_is_branch  (resolve_is_branch),
        .resolve_is_jump    (resolve_is_jump),
        .resolve_is_jr      (resolve_is_jr),
        .resolve_cond       (resolve_cond),
        .resolve_immed      (resolve_immed),
        .resolve_jr_target  (resolve_jr_target),
        .resolve_pred_taken (resolve_pred_taken),
        .resolve_pred_pc    (resolve_pred_pc),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .miss_count         (miss_count)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one resolving instruction onto the resolve port (no clocking).
    task automatic applyStimulus(input logic [15:0] pc, input logic isb, input logic isj,
                                 input logic isjr, input logic cond, input logic [15:0] immed,
                                 input logic [15:0] jrt, input logic [15:0] predpc);
        resolve_valid      = 1'b1;
        resolve_pc         = pc;
        resolve_is_branch  = isb;
        resolve_is_jump    = isj;
        resolve_is_jr      = isjr;
        resolve_cond       = cond;
        resolve_immed      = immed;
        resolve_jr_target  = jrt;
        resolve_pred_taken = 1'b0;
        resolve_pred_pc    = predpc;
    endtask

    // Advance one clock edge, then drop resolve_valid 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        resolve_valid = 1'b0;
    endtask

    // Present a fetch PC and check the combinational prediction.
    task automatic checkFetch(input string tag, input logic [15:0] pc, input logic expTaken, input logic [15:0] expPc);
        fetch_pc = pc;
        #1;
        checkOutput({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, expTaken});
        checkOutput({tag, ".npc"}, {16'd0, pred_next_pc}, {16'd0, expPc});
    endtask

    // Check the registered redirect outputs and the miss counter.
    task automatic checkRedirect(input string tag, input logic expRedir, input logic [15:0] expPc, input logic [15:0] expMiss);
        checkOutput({tag, ".redirect"}, {31'd0, redirect}, {31'd0, expRedir});
        checkOutput({tag, ".redirect_pc"}, {16'd0, redirect_pc}, {16'd0, expPc});
        checkOutput({tag, ".miss_count"}, {16'd0, miss_count}, {16'd0, expMiss});
    endtask

    // Directed scenario sequence.
    initial begin
        rst_n = 1'b0;
        fetch_pc = 16'h0000;
        applyStimulus(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        resolve_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        checkFetch("reset_fetch", 16'h0040, 1'b0, 16'h0042);
        checkRedirect("reset", 1'b0, 16'h0000, 16'd0);

        // Taken branch at 0010 allocates with ctr=10 and redirects to 0032
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0012);
        tick();
        checkRedirect("br_alloc", 1'b1, 16'h0032, 16'd1);
        tick();
        checkOutput("br_alloc.pulse_end", {31'd0, redirect}, 32'd0);
        checkFetch("br_alloc_fetch", 16'h0010, 1'b1, 16'h0032);

        // Two back-to-back not-taken resolves: ctr 10 -> 01 -> 00
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0032);
        tick();
        checkRedirect("br_nt1", 1'b1, 16'h0012, 16'd2);
        checkFetch("br_nt1_fetch", 16'h0010, 1'b0, 16'h0012);
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0032);
        tick();
        checkRedirect("br_nt2", 1'b1, 16'h0012, 16'd3);
        checkFetch("br_nt2_fetch", 16'h0010, 1'b0, 16'h0012);

        // JR at 0100 allocates index 0 with ctr=11, evicting 0010
        applyStimulus(16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 16'h0102);
        tick();
        checkRedirect("jr", 1'b1, 16'hBEEF, 16'd4);
        checkFetch("jr_fetch", 16'h0100, 1'b1, 16'hBEEF);
        checkFetch("jr_evict_fetch", 16'h0010, 1'b0, 16'h0012);

        // Not-taken branch on the JR entry: ctr 11 -> 10 still predicts taken
        applyStimulus(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF);
        tick();
        checkRedirect("jr_dec", 1'b1, 16'h0102, 16'd5);
        checkFetch("jr_dec_fetch", 16'h0100, 1'b1, 16'hBEEF);

        // Re-allocate 0010, then a non-control alias at 0010 clears it
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0012);
        tick();
        checkRedirect("realloc", 1'b1, 16'h0032, 16'd6);
        checkFetch("realloc_fetch", 16'h0010, 1'b1, 16'h0032);
        applyStimulus(16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0012);
        tick();
        checkRedirect("alias", 1'b0, 16'h0032, 16'd6);
        checkFetch("alias_fetch", 16'h0010, 1'b0, 16'h0012);

        // Same-cycle allocate and fetch of 0010
        fetch_pc = 16'h0010;
        applyStimulus(16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0012);
        #1;
`ifdef NPC_BYPASS_EN
        checkOutput("same_cycle.npc", {16'd0, pred_next_pc}, 32'h0032);
`else
        checkOutput("same_cycle.npc", {16'd0, pred_next_pc}, 32'h0012);
`endif
        tick();
        checkRedirect("same_cycle", 1'b1, 16'h0032, 16'd7);
        checkFetch("same_cycle_after", 16'h0010, 1'b1, 16'h0032);

        // Branch and jump both set acts as a jump: taken despite cond=0
        applyStimulus(16'h0026, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0028);
        tick();
        checkRedirect("br_and_jmp", 1'b1, 16'h0038, 16'd8);
        checkFetch("br_and_jmp_fetch", 16'h0026, 1'b1, 16'h0038);

        // is_jr without is_jump is ignored: immediate target is used
        applyStimulus(16'h0030, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 16'hDEAD, 16'h0032);
        tick();
        checkRedirect("jr_no_jump", 1'b1, 16'h0036, 16'd9);

        // Correctly predicted resolve: no redirect, count held
        applyStimulus(16'h0026, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0038);
        tick();
        checkRedirect("correct_pred", 1'b0, 16'h0036, 16'd9);

        // Reset during a mispredicting resolve discards it
        rst_n = 1'b0;
        applyStimulus(16'h0200, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234, 16'h0202);
        tick();
        rst_n = 1'b1;
        checkRedirect("reset_resolve", 1'b0, 16'h0000, 16'd0);
        checkFetch("reset_fetch_0010", 16'h0010, 1'b0, 16'h0012);
        checkFetch("reset_fetch_0200", 16'h0200, 1'b0, 16'h0202);
        tick();
        checkOutput("reset_resolve.later", {31'd0, redirect}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
